// File: rtl/lbp_stream_pkg.sv
// Shared definitions for the streaming LBP engine: FSM states, code bit
// positions and the border-address count.
package lbp_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_DRAIN  = 3'd2,
        S_BORDER = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam int LBP_CODE_W = 8;

    localparam int LBP_TL = 0;
    localparam int LBP_T  = 1;
    localparam int LBP_TR = 2;
    localparam int LBP_L  = 3;
    localparam int LBP_R  = 4;
    localparam int LBP_BL = 5;
    localparam int LBP_B  = 6;
    localparam int LBP_BR = 7;

    function automatic int border_count(input int w, input int h);
        return 2 * w + 2 * (h - 2);
    endfunction

endpackage

// File: rtl/lbp_stream_if.sv
// Host-side bus of the LBP engine: gray image read port, frame
// configuration and the result write port.
interface lbp_stream_if
    import lbp_stream_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
);
    logic                  gray_ready;
    logic                  gray_req;
    logic [ADDR_W-1:0]     gray_addr;
    logic [PIX_W-1:0]      gray_data;
    logic                  mode;
    logic [PIX_W-1:0]      thr;
    logic                  border_mode;
    logic [ADDR_W-1:0]     lbp_addr;
    logic                  lbp_valid;
    logic [LBP_CODE_W-1:0] lbp_data;
    logic                  finish;

    modport slave (
        input  gray_ready, gray_data, mode, thr, border_mode,
        output gray_req, gray_addr, lbp_addr, lbp_valid, lbp_data, finish
    );

    modport master (
        output gray_ready, gray_data, mode, thr, border_mode,
        input  gray_req, gray_addr, lbp_addr, lbp_valid, lbp_data, finish
    );
endinterface

// File: rtl/lbp_stream_line_buf.sv
// One image row of delay: the pixel leaving dout_o was pushed IMG_W pushes
// earlier, i.e. the same column of the previous row.
module lbp_line_buf #(
    parameter int IMG_W = 128,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             push_i,
    input  logic [PIX_W-1:0] din_i,
    output logic [PIX_W-1:0] dout_o
);
    logic [PIX_W-1:0] sr_q [IMG_W];

    always_ff @(posedge clk) begin
        if (push_i) begin
            sr_q[0] <= din_i;
            for (int i = 1; i < IMG_W; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout_o = sr_q[IMG_W-1];
endmodule

// File: rtl/lbp_stream.sv
// Streaming 3x3 LBP engine: fetches each gray pixel once, forms the window
// from two line buffers and writes one code per interior pixel.
module lbp_stream
    import lbp_stream_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
) (
    input  logic         clk,
    input  logic         reset,
    lbp_stream_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST    = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] COL_LAST    = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] CENTER_OFS  = ADDR_W'(IMG_W + 1);
    localparam logic [ADDR_W-1:0] TWO         = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ONE         = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] BORDER_LAST = ADDR_W'(border_count(IMG_W, IMG_H) - 1);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [PIX_W-1:0]      thr_q, thr_d;
    logic                  border_q, border_d;
    logic [ADDR_W-1:0]     gaddr_q, gaddr_d;
    logic [ADDR_W-1:0]     row_q, row_d;
    logic [ADDR_W-1:0]     col_q, col_d;
    logic [ADDR_W-1:0]     bcnt_q, bcnt_d;
    logic                  lbp_valid_q, lbp_valid_d;
    logic [ADDR_W-1:0]     lbp_addr_q, lbp_addr_d;
    logic [LBP_CODE_W-1:0] lbp_data_q, lbp_data_d;

    logic                  xfer;
    logic [PIX_W-1:0]      lb1_out, lb2_out;
    logic [PIX_W-1:0]      win_q [3][3];
    logic [PIX_W-1:0]      win_d [3][3];
    logic [PIX_W:0]        lim;
    logic [LBP_CODE_W-1:0] code;

    // Threshold kept one bit wider so center+thr never wraps; an oversized
    // limit simply makes every neighbour compare false.
    function automatic logic [PIX_W:0] margin_limit(input logic [PIX_W-1:0] c,
                                                    input logic [PIX_W-1:0] t,
                                                    input logic m);
        logic [PIX_W:0] s;
        s = {1'b0, c};
        if (m) s = s + {1'b0, t};
        return s;
    endfunction

    function automatic logic at_least(input logic [PIX_W-1:0] n, input logic [PIX_W:0] l);
        return {1'b0, n} >= l;
    endfunction

    assign xfer = (state_q == S_READ) && bus.gray_ready;

    lbp_line_buf #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb1 (
        .clk(clk), .push_i(xfer), .din_i(bus.gray_data), .dout_o(lb1_out)
    );

    lbp_line_buf #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb2 (
        .clk(clk), .push_i(xfer), .din_i(lb1_out), .dout_o(lb2_out)
    );

    // Row 0 = two rows up, row 1 = previous row, row 2 = incoming row; column 2 newest.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb2_out;
        win_d[1][2] = lb1_out;
        win_d[2][2] = bus.gray_data;
    end

    always_comb begin
        lim          = margin_limit(win_d[1][1], thr_q, mode_q);
        code         = '0;
        code[LBP_TL] = at_least(win_d[0][0], lim);
        code[LBP_T]  = at_least(win_d[0][1], lim);
        code[LBP_TR] = at_least(win_d[0][2], lim);
        code[LBP_L]  = at_least(win_d[1][0], lim);
        code[LBP_R]  = at_least(win_d[1][2], lim);
        code[LBP_BL] = at_least(win_d[2][0], lim);
        code[LBP_B]  = at_least(win_d[2][1], lim);
        code[LBP_BR] = at_least(win_d[2][2], lim);
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        thr_d       = thr_q;
        border_d    = border_q;
        gaddr_d     = gaddr_q;
        row_d       = row_q;
        col_d       = col_q;
        bcnt_d      = bcnt_q;
        lbp_valid_d = 1'b0;
        lbp_addr_d  = lbp_addr_q;
        lbp_data_d  = lbp_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.gray_ready) begin
                    state_d  = S_READ;
                    mode_d   = bus.mode;
                    thr_d    = bus.thr;
                    border_d = bus.border_mode;
                    gaddr_d  = '0;
                    row_d    = '0;
                    col_d    = '0;
                end
            end
            S_READ: begin
                if (xfer) begin
                    if (row_q >= TWO && col_q >= TWO) begin
                        lbp_valid_d = 1'b1;
                        lbp_addr_d  = gaddr_q - CENTER_OFS;
                        lbp_data_d  = code;
                    end
                    if (gaddr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        gaddr_d = gaddr_q + ONE;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + ONE;
                        end else begin
                            col_d = col_q + ONE;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (border_q) begin
                    state_d     = S_BORDER;
                    lbp_valid_d = 1'b1;
                    lbp_addr_d  = '0;
                    lbp_data_d  = '0;
                    row_d       = '0;
                    col_d       = '0;
                    bcnt_d      = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_BORDER: begin
                // row_q/col_q track the border address currently on the bus.
                if (bcnt_q == BORDER_LAST) begin
                    state_d = S_DONE;
                end else begin
                    lbp_valid_d = 1'b1;
                    lbp_data_d  = '0;
                    bcnt_d      = bcnt_q + ONE;
                    if (row_q != '0 && row_q != ROW_LAST && col_q == '0) begin
                        col_d      = COL_LAST;
                        lbp_addr_d = lbp_addr_q + COL_LAST;
                    end else if (col_q == COL_LAST) begin
                        col_d      = '0;
                        row_d      = row_q + ONE;
                        lbp_addr_d = lbp_addr_q + ONE;
                    end else begin
                        col_d      = col_q + ONE;
                        lbp_addr_d = lbp_addr_q + ONE;
                    end
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            thr_q       <= '0;
            border_q    <= 1'b0;
            gaddr_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            bcnt_q      <= '0;
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            thr_q       <= thr_d;
            border_q    <= border_d;
            gaddr_q     <= gaddr_d;
            row_q       <= row_d;
            col_q       <= col_d;
            bcnt_q      <= bcnt_d;
            lbp_valid_q <= lbp_valid_d;
            lbp_addr_q  <= lbp_addr_d;
            lbp_data_q  <= lbp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) win_q <= win_d;
    end

    assign bus.gray_req  = (state_q == S_READ);
    assign bus.gray_addr = gaddr_q;
    assign bus.lbp_valid = lbp_valid_q;
    assign bus.lbp_addr  = lbp_addr_q;
    assign bus.lbp_data  = lbp_data_q;
    assign bus.finish    = (state_q == S_DONE);
endmodule
